// File: rtl/snake_engine_pkg.sv
// snake_engine_pkg: shared constants, cell type and helpers for the snake game-state stage.
// Default field geometry, direction and state encodings, LFSR polynomial step.
package snake_engine_pkg;

    localparam int unsigned DEF_SIZE_X    = 16;
    localparam int unsigned DEF_SIZE_Y    = 12;
    localparam int unsigned DEF_SIZE_XY   = DEF_SIZE_X * DEF_SIZE_Y - 1;
    localparam int unsigned DEF_MAX_LEN   = 64;
    localparam logic [7:0]  DEF_LFSR_SEED = 8'hA5;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PLACE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } cell_t;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting towards the MSB
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Flat bitmap position of a cell: x * size_y + y
    function automatic int unsigned cell_index(input cell_t c, input int unsigned size_y);
        return 32'(c.x) * size_y + 32'(c.y);
    endfunction

endpackage

// File: rtl/snake_lfsr8.sv
// snake_lfsr8: free-running 8-bit placement LFSR, reloaded with the seed on reset.
// A zero seed is replaced by 1 so the register can never lock up at all-zero.
module snake_lfsr8
    import snake_engine_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] seed_i,
    output logic [7:0] state_o
);

    // Load seed on reset, otherwise advance one step every cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_o <= (seed_i == 8'h00) ? 8'h01 : seed_i;
        end else begin
            state_o <= lfsr8_next(state_o);
        end
    end

endmodule

// File: rtl/snake_engine.sv
// snake_engine: snake game state (body ring buffer + mirrored occupancy bitmap,
// direction latch, apple placement, score) feeding the field renderer.
// Build option: define SNAKE_WRAP_EN to make the field toroidal; otherwise
// leaving the field ends the game.
module snake_engine
    import snake_engine_pkg::*;
#(
    parameter int unsigned SIZE_X    = DEF_SIZE_X,
    parameter int unsigned SIZE_Y    = DEF_SIZE_Y,
    parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
    parameter logic [7:0]  LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     step_i,
    input  logic                     start_i,
    input  logic [1:0]               dir_i,
    output logic [SIZE_X*SIZE_Y-1:0] snake_tail_o,
    output logic [3:0]               apple_x_o,
    output logic [3:0]               apple_y_o,
    output logic [7:0]               score_o,
    output logic                     game_over_o,
    output logic                     busy_o
);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam int unsigned NCELL = SIZE_X * SIZE_Y;
    localparam int unsigned IW    = $clog2(NCELL);
    localparam int unsigned PW    = $clog2(MAX_LEN);

    localparam logic [4:0]  LIM_X   = 5'(SIZE_X);
    localparam logic [4:0]  LIM_Y   = 5'(SIZE_Y);
    localparam logic [3:0]  MAX_X   = 4'(SIZE_X - 1);
    localparam logic [3:0]  MAX_Y   = 4'(SIZE_Y - 1);
    localparam logic [PW:0] LEN_MAX = (PW+1)'(MAX_LEN);
    localparam logic [PW:0] LEN_RST = (PW+1)'(3);

    localparam cell_t RST_C0    = '{x: 4'(SIZE_X/2 - 2), y: 4'(SIZE_Y/2)};
    localparam cell_t RST_C1    = '{x: 4'(SIZE_X/2 - 1), y: 4'(SIZE_Y/2)};
    localparam cell_t RST_C2    = '{x: 4'(SIZE_X/2),     y: 4'(SIZE_Y/2)};
    localparam cell_t RST_APPLE = '{x: 4'(SIZE_X/2 + 4), y: 4'(SIZE_Y/2)};

    localparam logic [IW-1:0] RST_I0 = IW'(cell_index(RST_C0, SIZE_Y));
    localparam logic [IW-1:0] RST_I1 = IW'(cell_index(RST_C1, SIZE_Y));
    localparam logic [IW-1:0] RST_I2 = IW'(cell_index(RST_C2, SIZE_Y));

    logic [1:0]       state;
    cell_t            body [MAX_LEN];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic [PW-1:0]    head_nxt;
    logic [PW:0]      len;
    logic [NCELL-1:0] bitmap;
    logic [1:0]       next_dir;
    logic [1:0]       last_dir;
    cell_t            apple;
    logic [7:0]       score;
    logic [7:0]       lfsr;

    cell_t            head;
    cell_t            tail;
    cell_t            nh;
    cell_t            cand;
    logic             oob;
    logic [IW-1:0]    nh_idx;
    logic [IW-1:0]    tail_idx;
    logic [IW-1:0]    cand_idx;
    logic             eat;
    logic             grow;
    logic             hit;
    logic             collide;
    logic             do_move;
    logic             move_ok;
    logic             restart;
    logic             cand_ok;

    snake_lfsr8 u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .seed_i  (LFSR_SEED),
        .state_o (lfsr)
    );

    assign head     = body[head_ptr];
    assign tail     = body[tail_ptr];
    assign head_nxt = head_ptr + 1'b1;

    // Next head cell from the latched direction; out-of-field handled by build option
    always_comb begin
        nh  = head;
        oob = 1'b0;
        unique case (next_dir)
            DIR_UP: begin
                if (head.y == 4'd0) begin
                    if (WRAP_EN) nh.y = MAX_Y;
                    else         oob  = 1'b1;
                end else begin
                    nh.y = head.y - 4'd1;
                end
            end
            DIR_RIGHT: begin
                if (head.x == MAX_X) begin
                    if (WRAP_EN) nh.x = 4'd0;
                    else         oob  = 1'b1;
                end else begin
                    nh.x = head.x + 4'd1;
                end
            end
            DIR_DOWN: begin
                if (head.y == MAX_Y) begin
                    if (WRAP_EN) nh.y = 4'd0;
                    else         oob  = 1'b1;
                end else begin
                    nh.y = head.y + 4'd1;
                end
            end
            default: begin
                if (head.x == 4'd0) begin
                    if (WRAP_EN) nh.x = MAX_X;
                    else         oob  = 1'b1;
                end else begin
                    nh.x = head.x - 4'd1;
                end
            end
        endcase
    end

    assign nh_idx   = IW'(cell_index(nh, SIZE_Y));
    assign tail_idx = IW'(cell_index(tail, SIZE_Y));

    assign eat     = (nh == apple);
    assign grow    = eat && (len < LEN_MAX);
    // The tail cell is vacated in the same edge, so entering it is legal unless growing
    assign hit     = bitmap[nh_idx] && !((nh == tail) && !grow);
    assign collide = oob || hit;
    assign do_move = (state == ST_RUN) && step_i;
    assign move_ok = do_move && !collide;
    assign restart = (state == ST_OVER) && start_i;

    assign cand     = '{x: lfsr[3:0], y: lfsr[7:4]};
    assign cand_idx = IW'(cell_index(cand, SIZE_Y));
    assign cand_ok  = ({1'b0, cand.x} < LIM_X) && ({1'b0, cand.y} < LIM_Y) && !bitmap[cand_idx];

    // Game state: reset/restart load, moves, apple placement
    always_ff @(posedge clk_i) begin
        if (rst_i || restart) begin
            state          <= rst_i ? ST_IDLE : ST_RUN;
            body[0]        <= RST_C0;
            body[1]        <= RST_C1;
            body[2]        <= RST_C2;
            tail_ptr       <= '0;
            head_ptr       <= PW'(2);
            len            <= LEN_RST;
            bitmap         <= '0;
            bitmap[RST_I0] <= 1'b1;
            bitmap[RST_I1] <= 1'b1;
            bitmap[RST_I2] <= 1'b1;
            apple          <= RST_APPLE;
            score          <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_i) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (do_move) begin
                        if (collide) begin
                            state <= ST_OVER;
                        end else begin
                            if (grow) begin
                                len <= len + 1'b1;
                            end else begin
                                bitmap[tail_idx] <= 1'b0;
                                tail_ptr         <= tail_ptr + 1'b1;
                            end
                            // Later assignment wins on a tail chase, keeping the cell set
                            bitmap[nh_idx] <= 1'b1;
                            body[head_nxt] <= nh;
                            head_ptr       <= head_nxt;
                            if (eat) begin
                                score <= (score == 8'hFF) ? score : score + 8'd1;
                                state <= ST_PLACE;
                            end
                        end
                    end
                end
                ST_PLACE: begin
                    if (cand_ok) begin
                        apple <= cand;
                        state <= ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Direction latch: reject reversal relative to the last executed move
    always_ff @(posedge clk_i) begin
        if (rst_i || restart) begin
            next_dir <= DIR_RIGHT;
            last_dir <= DIR_RIGHT;
        end else begin
            if (dir_i != (last_dir ^ 2'd2)) next_dir <= dir_i;
            if (move_ok)                    last_dir <= next_dir;
        end
    end

    assign snake_tail_o = bitmap;
    assign apple_x_o    = apple.x;
    assign apple_y_o    = apple.y;
    assign score_o      = score;
    assign game_over_o  = (state == ST_OVER);
    assign busy_o       = (state == ST_PLACE);

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed scenarios followed by random play, every cycle
// compared with a queue-based reference model of the game rules.
module tb_snake_engine;

    localparam int SX   = 16;
    localparam int SY   = 12;
    localparam int NC   = SX * SY;
    localparam int MAXL = 64;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum int {M_IDLE, M_RUN, M_PLACE, M_OVER} mstate_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          step_i = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    dir_i = 2'd1;
    logic [NC-1:0] snake_tail_o;
    logic [3:0]    apple_x_o;
    logic [3:0]    apple_y_o;
    logic [7:0]    score_o;
    logic          game_over_o;
    logic          busy_o;

    int n_cmp = 0;
    int n_err = 0;

    int         qx[$];
    int         qy[$];
    int         ax, ay, score_m;
    mstate_t    st_m;
    logic [1:0] nd_m, ld_m;
    logic [7:0] lf_m;
    int         DX[4] = '{0, 1, 0, -1};
    int         DY[4] = '{-1, 0, 1, 0};
    logic [NC-1:0] rst_map;

    snake_engine dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .step_i       (step_i),
        .start_i      (start_i),
        .dir_i        (dir_i),
        .snake_tail_o (snake_tail_o),
        .apple_x_o    (apple_x_o),
        .apple_y_o    (apple_y_o),
        .score_o      (score_o),
        .game_over_o  (game_over_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    function automatic bit occupied(input int x, input int y);
        foreach (qx[i]) if (qx[i] == x && qy[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NC-1:0] model_map();
        logic [NC-1:0] m;
        m = '0;
        foreach (qx[i]) m[qx[i] * SY + qy[i]] = 1'b1;
        return m;
    endfunction

    task automatic model_init();
        qx = '{SX/2, SX/2 - 1, SX/2 - 2};
        qy = '{SY/2, SY/2, SY/2};
        ax = SX/2 + 4;
        ay = SY/2;
        score_m = 0;
        nd_m = 2'd1;
        ld_m = 2'd1;
    endtask

    task automatic model_move(input logic [1:0] d);
        int nx, ny;
        bit oob, eat, grow, at_tail, hit;
        nx = qx[0] + DX[d];
        ny = qy[0] + DY[d];
        oob = 1'b0;
        if (WRAP) begin
            nx = (nx + SX) % SX;
            ny = (ny + SY) % SY;
        end else begin
            oob = (nx < 0) || (nx >= SX) || (ny < 0) || (ny >= SY);
        end
        eat     = (nx == ax) && (ny == ay);
        grow    = eat && (qx.size() < MAXL);
        at_tail = (nx == qx[$]) && (ny == qy[$]);
        hit     = !oob && occupied(nx, ny) && !(at_tail && !grow);
        if (oob || hit) begin
            st_m = M_OVER;
            return;
        end
        qx.push_front(nx);
        qy.push_front(ny);
        if (!grow) begin
            void'(qx.pop_back());
            void'(qy.pop_back());
        end
        ld_m = d;
        if (eat) begin
            if (score_m < 255) score_m++;
            st_m = M_PLACE;
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit st, input logic [1:0] d);
        logic [1:0] old_nd;
        int cx, cy;
        if (r) begin
            model_init();
            lf_m = SEED;
            st_m = M_IDLE;
            return;
        end
        old_nd = nd_m;
        if (d != (ld_m ^ 2'd2)) nd_m = d;
        case (st_m)
            M_IDLE:  if (st) st_m = M_RUN;
            M_RUN:   if (s) model_move(old_nd);
            M_PLACE: begin
                cx = int'(lf_m[3:0]);
                cy = int'(lf_m[7:4]);
                if (cx < SX && cy < SY && !occupied(cx, cy)) begin
                    ax = cx;
                    ay = cy;
                    st_m = M_RUN;
                end
            end
            default: if (st) begin
                model_init();
                st_m = M_RUN;
            end
        endcase
        lf_m = lfsr_step(lf_m);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bitmap",    snake_tail_o, model_map());
        chk("apple_x",   apple_x_o, 256'(ax));
        chk("apple_y",   apple_y_o, 256'(ay));
        chk("score",     score_o, 256'(score_m));
        chk("game_over", game_over_o, 256'(st_m == M_OVER));
        chk("busy",      busy_o, 256'(st_m == M_PLACE));
    endtask

    task automatic tick(input bit r, input bit s, input bit st, input logic [1:0] d);
        rst_i = r;
        step_i = s;
        start_i = st;
        dir_i = d;
        model_edge(r, s, st, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Latch a direction for one cycle, then step with it held
    task automatic mv(input logic [1:0] d);
        tick(1'b0, 1'b0, 1'b0, d);
        tick(1'b0, 1'b1, 1'b0, d);
    endtask

    initial begin
        int guard;
        rst_map = '0;
        rst_map[8 * SY + 6] = 1'b1;
        rst_map[7 * SY + 6] = 1'b1;
        rst_map[6 * SY + 6] = 1'b1;

        // Reset values
        tick(1'b1, 1'b0, 1'b0, 2'd1);
        tick(1'b1, 1'b0, 1'b0, 2'd1);
        chk("rst_map", snake_tail_o, rst_map);
        chk("rst_apple_x", apple_x_o, 12);
        chk("rst_apple_y", apple_y_o, 6);
        chk("rst_score", score_o, 0);
        chk("rst_over", game_over_o, 0);
        chk("rst_busy", busy_o, 0);

        // Step ignored in IDLE, then four right steps eat the apple at (12,6)
        tick(1'b0, 1'b1, 1'b0, 2'd1);
        chk("idle_step", snake_tail_o, rst_map);
        tick(1'b0, 1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 2'd1);
        chk("eat_score", score_o, 1);
        chk("eat_busy", busy_o, 1);
        // Steps while placing are dropped
        guard = 0;
        while (busy_o === 1'b1 && guard < 300) begin
            tick(1'b0, 1'b1, 1'b0, 2'd1);
            guard++;
        end
        chk("place_done", busy_o, 0);

        // 2x2 square into the vacating tail
        mv(2'd0);
        mv(2'd3);
        mv(2'd2);
        mv(2'd1);

        // Reset while in PLACE
        tick(1'b1, 1'b0, 1'b0, 2'd1);
        tick(1'b0, 1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 4; i++) mv(2'd1);
        chk("place_busy", busy_o, 1);
        tick(1'b1, 1'b0, 1'b0, 2'd1);
        chk("place_rst_map", snake_tail_o, rst_map);
        chk("place_rst_score", score_o, 0);
        chk("place_rst_busy", busy_o, 0);

        // Run off the top edge
        tick(1'b0, 1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 7; i++) mv(2'd0);
`ifndef SNAKE_WRAP_EN
        chk("oob_over", game_over_o, 1);
        chk("oob_map", snake_tail_o[8 * SY + 0], 1);
        // Start with step in OVER: restart wins, no move this edge
        tick(1'b0, 1'b1, 1'b1, 2'd1);
        chk("restart_over", game_over_o, 0);
        chk("restart_map", snake_tail_o, rst_map);
        chk("restart_score", score_o, 0);
`else
        chk("wrap_over", game_over_o, 0);
        chk("wrap_head", snake_tail_o[8 * SY + 11], 1);
`endif

        // Reversal rejection
        tick(1'b1, 1'b0, 1'b0, 2'd1);
        tick(1'b0, 1'b0, 1'b1, 2'd1);
        tick(1'b0, 1'b0, 1'b0, 2'd3);
        tick(1'b0, 1'b1, 1'b0, 2'd3);
        chk("rev_right", snake_tail_o[9 * SY + 6], 1);
        tick(1'b0, 1'b0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 1'b0, 2'd3);
        tick(1'b0, 1'b1, 1'b0, 2'd3);
        chk("rev_up", snake_tail_o[9 * SY + 5], 1);
        chk("rev_alive", game_over_o, 0);

        // Random play
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 999) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0,
                 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
